// File: rtl/cam_pkg.sv
// ============================================================================
// Module      : cam_pkg
// Description : Shared types and constants for the pixel readout receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cam_pkg;

   localparam int DEFAULT_ADC_W = 8;
   localparam int DEFAULT_COLS  = 2;

   localparam logic ROW0 = 1'b0;
   localparam logic ROW1 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPOSE = 2'd1,
      ST_ROW0   = 2'd2,
      ST_ROW1   = 2'd3
   } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/pixel_readout_rx_if.sv
// ============================================================================
// Module      : pixel_readout_rx_if
// Description : Per-pixel valid/ready stream from the receiver to the frame sink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pixel_readout_rx_if #(
   parameter int ADC_W = 8,
   parameter int COLS  = 2
);
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

   logic             out_valid;
   logic             out_ready;
   logic [ADC_W-1:0] out_data;
   logic             out_row;
   logic [COL_W-1:0] out_col;
   logic             out_last;

   modport master (
      output out_valid, out_data, out_row, out_col, out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_data, out_row, out_col, out_last,
      output out_ready
   );
endinterface

`default_nettype wire

// File: rtl/row_fifo.sv
// ============================================================================
// Module      : row_fifo
// Description : Two-entry row buffer; a full FIFO still accepts a write when
//               the head row is popped in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module row_fifo #(
   parameter int ADC_W = 8,
   parameter int COLS  = 2
) (
   input  wire logic                       clk,
   input  wire logic                       reset,
   input  wire logic                       push,
   input  wire logic [COLS-1:0][ADC_W-1:0] push_data,
   input  wire logic                       push_row,
   input  wire logic                       push_last,
   input  wire logic                       pop,
   output logic                            can_push,
   output logic                            head_valid,
   output logic [COLS-1:0][ADC_W-1:0]      head_data,
   output logic                            head_row,
   output logic                            head_last
);

   typedef struct packed {
      logic [COLS-1:0][ADC_W-1:0] data;
      logic                       row;
      logic                       last;
   } entry_t;

   entry_t     r_mem [2];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (push) begin
            r_mem[r_wr_ptr] <= '{data: push_data, row: push_row, last: push_last};
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({push, pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign can_push   = (r_count != 2'd2) | pop;
   assign head_valid = (r_count != 2'd0);
   assign head_data  = r_mem[r_rd_ptr].data;
   assign head_row   = r_mem[r_rd_ptr].row;
   assign head_last  = r_mem[r_rd_ptr].last;

endmodule

`default_nettype wire

// File: rtl/pixel_readout_rx.sv
// ============================================================================
// Module      : pixel_readout_rx
// Description : Readout receiver: ADC edge detect, sequencing FSM, row capture,
//               two-row buffering and per-pixel serialisation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_readout_rx
   import cam_pkg::*;
#(
   parameter int ADC_W = DEFAULT_ADC_W,
   parameter int COLS  = DEFAULT_COLS
) (
   input  wire logic                  clk,
   input  wire logic                  reset,
   input  wire logic                  Expose,
   input  wire logic                  Erase,
   input  wire logic                  NRE_1,
   input  wire logic                  NRE_2,
   input  wire logic                  ADC,
   input  wire logic [COLS*ADC_W-1:0] adc_data,
   pixel_readout_rx_if.master         pix,
   output logic                       frame_done,
   output logic                       err_seq,
   output logic                       err_ovf
);

   localparam int               COL_W      = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [COL_W-1:0] c_LAST_COL = COL_W'(COLS - 1);

   rx_state_t                  r_state;
   rx_state_t                  w_state_nxt;
   logic                       r_adc_q;
   logic [COL_W-1:0]           r_col;
   logic                       r_frame_done;
   logic                       r_err_seq;
   logic                       r_err_ovf;

   logic                       w_strobe;
   logic                       w_row_ok;
   logic                       w_row_sel;
   logic                       w_row_match;
   logic                       w_capture_req;
   logic                       w_can_push;
   logic                       w_push;
   logic                       w_pop;
   logic                       w_at_last_col;
   logic                       w_head_valid;
   logic [COLS-1:0][ADC_W-1:0] w_head_data;
   logic                       w_head_row;
   logic                       w_head_last;

   assign w_strobe  = ADC & ~r_adc_q;
   // Exactly one active-low enable selects a row; NRE_1 low means row 0.
   assign w_row_ok  = NRE_1 ^ NRE_2;
   assign w_row_sel = NRE_1 ? ROW1 : ROW0;

   assign w_row_match   = ((r_state == ST_ROW0) && (w_row_sel == ROW0)) ||
                          ((r_state == ST_ROW1) && (w_row_sel == ROW1));
   assign w_capture_req = w_strobe & w_row_ok & w_row_match;
   assign w_push        = w_capture_req & w_can_push;

   assign w_at_last_col = (r_col == c_LAST_COL);
   assign w_pop         = w_head_valid & pix.out_ready & w_at_last_col;

   row_fifo #(
      .ADC_W (ADC_W),
      .COLS  (COLS)
   ) u_row_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (w_push),
      .push_data  (adc_data),
      .push_row   (w_row_sel),
      .push_last  (r_state == ST_ROW1),
      .pop        (w_pop),
      .can_push   (w_can_push),
      .head_valid (w_head_valid),
      .head_data  (w_head_data),
      .head_row   (w_head_row),
      .head_last  (w_head_last)
   );

   // Capture is evaluated before abort, so a row-1 capture with Erase still ends the frame.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (Expose) w_state_nxt = ST_EXPOSE;
         ST_EXPOSE: begin
            if (Erase)        w_state_nxt = ST_IDLE;
            else if (!Expose) w_state_nxt = ST_ROW0;
         end
         ST_ROW0: begin
            if (Erase)        w_state_nxt = ST_IDLE;
            else if (w_push)  w_state_nxt = ST_ROW1;
         end
         ST_ROW1:   if (Erase || w_push) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_adc_q      <= 1'b0;
         r_col        <= '0;
         r_frame_done <= 1'b0;
         r_err_seq    <= 1'b0;
         r_err_ovf    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_adc_q      <= ADC;
         r_frame_done <= w_pop & w_head_last;
         r_err_seq    <= w_strobe & ~w_capture_req;
         r_err_ovf    <= w_capture_req & ~w_can_push;
         if (w_head_valid && pix.out_ready) begin
            r_col <= w_at_last_col ? '0 : r_col + 1'b1;
         end
      end
   end

   assign pix.out_valid = w_head_valid;
   assign pix.out_data  = w_head_data[r_col];
   assign pix.out_row   = w_head_row;
   assign pix.out_col   = r_col;
   assign pix.out_last  = w_head_valid & w_head_last & w_at_last_col;

   assign frame_done = r_frame_done;
   assign err_seq    = r_err_seq;
   assign err_ovf    = r_err_ovf;

endmodule

`default_nettype wire

// File: doc/pixel_readout_rx.md
# pixel_readout_rx

Receiving end of the exposure-controller readout interface. Monitors the controller's Expose, Erase, NRE_1, NRE_2 and ADC strobes, and captures one row of column-ADC samples on each qualified ADC strobe. Buffers up to two rows and serialises them as a per-pixel valid/ready stream toward the frame sink. Flags sequencing violations and buffer overruns.

## Interface
- ADC_W, 8, bits per pixel sample
- COLS, 2, pixels per row (column ADCs sampled in parallel)
- clk  in  1  system clock; all inputs synchronous to it
- reset  in  1  asynchronous, active-high
- Expose, Erase  in  1 each  controller phase strobes
- NRE_1, NRE_2  in  1 each  active-low row enables (row 0 / row 1)
- ADC  in  1  conversion strobe; sampled on its rising edge
- adc_data  in  COLS*ADC_W  column samples; pixel c = adc_data[c*ADC_W +: ADC_W]
- out_valid  out  1  pixel available
- out_ready  in  1  sink accepts when out_valid & out_ready at posedge
- out_data  out  ADC_W  pixel value
- out_row  out  1  row index of pixel
- out_col  out  $clog2(COLS)  column index (min width 1)
- out_last  out  1  final pixel of a complete frame
- frame_done  out  1  one-cycle pulse when the out_last pixel is accepted
- err_seq  out  1  one-cycle pulse on protocol violation
- err_ovf  out  1  one-cycle pulse on dropped row (buffer full)

## Operation
- ADC edge: adc_q registers ADC; strobe = ADC & ~adc_q. adc_q resets to 0.
- Row decode at strobe: NRE_1=0 & NRE_2=1 selects row 0; NRE_2=0 & NRE_1=1 selects row 1; both low or both high raises err_seq, and the sample is dropped.
- FSM (rx_state_t): IDLE, EXPOSE, ROW0, ROW1.
  - IDLE -> EXPOSE when Expose=1.
  - EXPOSE -> ROW0 when Expose=0 & Erase=0.
  - ROW0 -> ROW1 on an accepted row-0 capture.
  - ROW1 -> IDLE on an accepted row-1 capture. That row is tagged last_frame_row.
  - Erase=1 in EXPOSE/ROW0/ROW1 -> IDLE (abort). Rows already buffered still drain; none of them is tagged last.
  - A strobe in IDLE or EXPOSE, or a strobe for the wrong row in ROW0/ROW1: err_seq, sample dropped, state unchanged.
- Row FIFO: 2 entries. Each entry holds {COLS samples, row bit, last_frame_row}.
  - Write accepted if count<2, or if the head row's final pixel is popped in the same cycle.
  - Otherwise err_ovf, the row is dropped, and the FSM does not advance.
- Serialiser: emits the head entry columns 0..COLS-1, advancing col on each handshake. Pops the entry after column COLS-1 is accepted.
- out_last = out_valid & head.last_frame_row & col==COLS-1.
- out_data, out_row, out_col and out_last stay stable while out_valid & ~out_ready.
- Reset values: state IDLE, FIFO empty, col 0. out_valid, out_data, out_row, out_col, out_last, frame_done, err_seq and err_ovf are all 0.

## Timing
- Strobe seen at posedge N (ADC=1, adc_q=0): row written at N. With the FIFO previously empty, out_valid=1 after N (visible in cycle N+1).
- Throughput: one pixel per cycle while out_ready=1. Back-to-back rows stream with no bubble.
- frame_done and err pulses are registered: high for exactly the cycle after the causing edge.
- Simultaneous strobe and Erase=1 in ROW0/ROW1: the capture is processed first, then abort applies. A row-1 capture in that cycle completes the frame normally.
- ADC held high for multiple cycles produces one capture only.
- Asynchronous reset mid-frame clears the FIFO and serialiser immediately. out_valid drops without a handshake.

## Structure
- Shared package (cam_pkg) holds:
  - the rx_state_t enum
  - the row index constants ROW0=1'b0 and ROW1=1'b1
  - the default ADC_W and COLS localparams
- Sub-module row_fifo: 2-entry FIFO with count, head/tail pointers and the simultaneous push/pop rule.
- Top level holds the edge detect, FSM, row decode, serialiser and error pulses.

## Test plan
- Full frame, out_ready=1, COLS=2, ADC_W=8:
  - Stimulus: Expose pulse; row-0 strobe with adc_data=16'hB2A1; row-1 strobe with 16'hD4C3.
  - Required: out_data A1, B2, C3, D4; out_row 0,0,1,1; out_col 0,1,0,1; out_last only on D4; frame_done one cycle later.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after the first valid.
  - Required: out_data=A1 held stable; no data lost after release.
- Overrun:
  - Stimulus: out_ready=0; two rows captured, then a third strobe from a new frame.
  - Required: err_ovf pulse; third row absent from output.
- Protocol errors:
  - Stimulus: strobe with NRE_1=NRE_2=0; also a strobe during EXPOSE.
  - Required: err_seq pulse each time; no output; FSM state unchanged.
- Abort:
  - Stimulus: Erase=1 after the row-0 capture.
  - Required: FSM to IDLE; row 0 still emitted with out_last=0; no frame_done.
- Reset mid-drain:
  - Stimulus: assert reset while out_valid=1.
  - Required: all outputs 0 asynchronously; a fresh frame afterwards is correct.
